mmio_controller: RTL and testbench

Single-master MMIO controller that sits directly upstream of the slot-interface cores (timer, GPIO, UART, …). It accepts one word-addressed request at a time from the processor side with a valid/ready handshake. It decodes the slot number, drives exactly one slot's `cs`/`read`/`write` strobes for one cycle, and returns the registered read data or write acknowledgement. Slot cores present combinational `rd_data` on their `address`; the controller samples it during the strobe cycle.

---
 rtl/mmio_controller.sv | 113 +++++++++++
 tb/tb_mmio_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_controller.sv
// Single-master MMIO controller: decodes a word address into one slot strobe
// for one cycle and returns registered read data or a write acknowledgement.
module mmio_controller #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_BITS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cpu_valid,
  output logic                      cpu_ready,
  input  logic                      cpu_we,
  input  logic [SLOT_BITS+4:0]      cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic                      cpu_done,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_err,
  output logic [NUM_SLOTS-1:0]      slot_cs,
  output logic                      slot_read,
  output logic                      slot_write,
  output logic [4:0]                slot_address,
  output logic [31:0]               slot_wr_data,
  input  logic [NUM_SLOTS*32-1:0]   slot_rd_data,
  output logic [1:0]                state_dbg
);

  // Handshake: a request transfers on a rising edge where cpu_valid and
  // cpu_ready are both 1; cpu_ready is 1 only in IDLE, so the next transfer
  // can happen no earlier than three edges later.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic                 accept;
  logic [SLOT_BITS-1:0] req_slot;
  logic                 req_hit;
  logic [NUM_SLOTS-1:0] cs_decode;
  logic [31:0]          rd_sel;
  logic                 lat_we;
  logic                 lat_hit;

  assign accept    = (state == IDLE) && cpu_valid;
  assign req_slot  = cpu_addr[SLOT_BITS+4:5];
  assign req_hit   = (int'(req_slot) < NUM_SLOTS);
  assign cpu_ready = (state == IDLE);
  assign cpu_done  = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu_valid) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decode is registered at acceptance so slot_* never sees cpu_* combinationally.
  always_comb begin
    cs_decode = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (int'(req_slot) == i) cs_decode[i] = 1'b1;
    end
  end

  // The registered one-hot select steers read data, so an unmapped slot yields 0.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_cs[i]) rd_sel = rd_sel | slot_rd_data[32*i +: 32];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_cs      <= '0;
      slot_read    <= 1'b0;
      slot_write   <= 1'b0;
      slot_address <= '0;
      slot_wr_data <= '0;
      cpu_rdata    <= '0;
      cpu_err      <= 1'b0;
      lat_we       <= 1'b0;
      lat_hit      <= 1'b0;
    end else begin
      if (accept) begin
        slot_cs      <= cs_decode;
        slot_read    <= req_hit & ~cpu_we;
        slot_write   <= req_hit & cpu_we;
        slot_address <= cpu_addr[4:0];
        slot_wr_data <= cpu_wdata;
        lat_we       <= cpu_we;
        lat_hit      <= req_hit;
      end else if (state == ACCESS) begin
        slot_cs    <= '0;
        slot_read  <= 1'b0;
        slot_write <= 1'b0;
        cpu_err    <= ~lat_hit;
        cpu_rdata  <= (lat_hit && !lat_we) ? rd_sel : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_controller.sv
// Bench for mmio_controller: an 8-slot instance backed by behavioural slot
// cores (timer at slot 0) and a 5-slot instance sharing the same request bus.
module tb_mmio_controller;
  localparam int SB = 3;
  localparam int AW = SB + 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          cpu_valid = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;

  logic          ready_a, done_a, err_a, read_a, write_a;
  logic [31:0]   rdata_a, wd_a;
  logic [7:0]    cs_a;
  logic [4:0]    addr_a;
  logic [255:0]  rd_a;
  logic [1:0]    dbg_a;

  logic          ready_b, done_b, err_b, read_b, write_b;
  logic [31:0]   rdata_b, wd_b;
  logic [4:0]    cs_b;
  logic [4:0]    addr_b;
  logic [159:0]  rd_b;
  logic [1:0]    dbg_b;

  mmio_controller #(.NUM_SLOTS(8), .SLOT_BITS(SB)) dut (
    .clock(clock), .reset(reset), .cpu_valid(cpu_valid), .cpu_ready(ready_a),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(done_a), .cpu_rdata(rdata_a), .cpu_err(err_a),
    .slot_cs(cs_a), .slot_read(read_a), .slot_write(write_a),
    .slot_address(addr_a), .slot_wr_data(wd_a), .slot_rd_data(rd_a),
    .state_dbg(dbg_a)
  );

  mmio_controller #(.NUM_SLOTS(5), .SLOT_BITS(SB)) dut5 (
    .clock(clock), .reset(reset), .cpu_valid(cpu_valid), .cpu_ready(ready_b),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(done_b), .cpu_rdata(rdata_b), .cpu_err(err_b),
    .slot_cs(cs_b), .slot_read(read_b), .slot_write(write_b),
    .slot_address(addr_b), .slot_wr_data(wd_b), .slot_rd_data(rd_b),
    .state_dbg(dbg_b)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(int i, int r);
    if (r == 2) return 32'hA000_0000 + 32'(i);
    return 32'h5000_0000 + 32'(i * 256 + r);
  endfunction

  // Slot cores for the 8-slot instance: slot 0 is a timer (reg0 ctrl, bit1 =
  // run; reg1 count, read-only), every other register is plain storage.
  logic [31:0] core_mem [8][32];
  logic [31:0] t_ctrl, t_count;
  logic        core_init = 1'b0;

  always @(posedge clock) begin
    if (core_init) begin
      for (int i = 0; i < 8; i++)
        for (int r = 0; r < 32; r++) core_mem[i][r] <= init_val(i, r);
      t_ctrl  <= '0;
      t_count <= '0;
    end else begin
      if (t_ctrl[1]) t_count <= t_count + 1;
      if (write_a) begin
        for (int i = 0; i < 8; i++) begin
          if (cs_a[i]) begin
            if (i == 0 && addr_a == 5'd0) t_ctrl <= wd_a;
            else if (!(i == 0 && addr_a == 5'd1)) core_mem[i][addr_a] <= wd_a;
          end
        end
      end
    end
  end

  always_comb begin
    rd_a = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 && addr_a == 5'd0)      rd_a[i*32 +: 32] = t_ctrl;
      else if (i == 0 && addr_a == 5'd1) rd_a[i*32 +: 32] = t_count;
      else                               rd_a[i*32 +: 32] = core_mem[i][addr_a];
    end
  end

  always_comb begin
    rd_b = '0;
    for (int i = 0; i < 5; i++) rd_b[i*32 +: 32] = 32'hB000_0000 + 32'(i);
  end

  // Reference model of the address map, updated per completed write.
  logic [31:0] ref_mem [8][32];
  logic [31:0] ref_ctrl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] slot, input logic [4:0] rg,
                        input logic [31:0] wd, input bit hold, output logic [31:0] got);
    int n;
    int s;
    int r;
    logic [31:0] exp_a, exp_b;
    s = int'(slot);
    r = int'(rg);
    cpu_valid = 1'b1;
    cpu_we    = we;
    cpu_addr  = {slot, rg};
    cpu_wdata = wd;
    n = 0;
    while (!ready_a && n < 8) begin
      @(posedge clock); #1;
      n++;
    end
    chk("ready_before_req", 32'(ready_a), 32'd1);
    @(posedge clock); #1;
    acc_cyc = cyc;
    if (!hold) cpu_valid = 1'b0;
    chk("access_cs_a", 32'(cs_a), 32'(1) << s);
    chk("access_write_a", 32'(write_a), 32'(we));
    chk("access_read_a", 32'(read_a), 32'(!we));
    chk("access_address", 32'(addr_a), 32'(r));
    chk("access_wr_data", wd_a, wd);
    chk("access_ready", 32'(ready_a), 32'd0);
    chk("access_done", 32'(done_a), 32'd0);
    chk("access_cs_b", 32'(cs_b), (s < 5) ? (32'(1) << s) : 32'd0);
    chk("access_write_b", 32'(write_b), 32'(we && s < 5));
    chk("access_read_b", 32'(read_b), 32'(!we && s < 5));
    if (we)                    exp_a = 32'd0;
    else if (s == 0 && r == 0) exp_a = ref_ctrl;
    else if (s == 0 && r == 1) exp_a = t_count;
    else                       exp_a = ref_mem[s][r];
    exp_b = (!we && s < 5) ? 32'hB000_0000 + 32'(s) : 32'd0;
    @(posedge clock); #1;
    chk("done_pulse_a", 32'(done_a), 32'd1);
    chk("done_rdata_a", rdata_a, exp_a);
    chk("done_err_a", 32'(err_a), 32'd0);
    chk("done_strobes_a", {cs_a, 22'd0, read_a, write_a}, 32'd0);
    chk("done_ready_a", 32'(ready_a), 32'd0);
    chk("done_pulse_b", 32'(done_b), 32'd1);
    chk("done_rdata_b", rdata_b, exp_b);
    chk("done_err_b", 32'(err_b), 32'(s >= 5));
    chk("done_strobes_b", {cs_b, 25'd0, read_b, write_b}, 32'd0);
    got = rdata_a;
    if (we) begin
      if (s == 0 && r == 0)       ref_ctrl = wd;
      else if (!(s == 0 && r == 1)) ref_mem[s][r] = wd;
    end
    @(posedge clock); #1;
    chk("idle_done_a", 32'(done_a), 32'd0);
    chk("idle_ready_a", 32'(ready_a), 32'd1);
    chk("idle_rdata_hold_a", rdata_a, exp_a);
    chk("idle_err_hold_b", 32'(err_b), 32'(s >= 5));
  endtask

  initial begin
    logic [31:0] got, r1, r2;
    int prev;
    for (int i = 0; i < 8; i++)
      for (int r = 0; r < 32; r++) ref_mem[i][r] = init_val(i, r);
    ref_ctrl = '0;

    reset = 1'b0;
    core_init = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    core_init = 1'b0;
    @(posedge clock); #1;
    chk("reset_ready_a", 32'(ready_a), 32'd1);
    chk("reset_done_a", 32'(done_a), 32'd0);
    chk("reset_err_a", 32'(err_a), 32'd0);
    chk("reset_rdata_a", rdata_a, 32'd0);
    chk("reset_strobes_a", {cs_a, 22'd0, read_a, write_a}, 32'd0);
    chk("reset_address_a", 32'(addr_a), 32'd0);
    chk("reset_wr_data_a", wd_a, 32'd0);
    chk("reset_ready_b", 32'(ready_b), 32'd1);
    chk("reset_outs_b", {cs_b, 22'd0, done_b, err_b, read_b, write_b}, 32'd0);
    chk("reset_rdata_b", rdata_b, 32'd0);

    // Timer at slot 0: start it, then two reads three cycles apart.
    do_req(1'b1, 3'd0, 5'd0, 32'h2, 1'b0, got);
    do_req(1'b0, 3'd0, 5'd1, 32'h0, 1'b0, r1);
    do_req(1'b0, 3'd0, 5'd1, 32'h0, 1'b0, r2);
    chk("timer_delta", r2 - r1, 32'd3);

    for (int i = 0; i < 8; i++) do_req(1'b0, 3'(i), 5'd2, 32'h0, 1'b0, got);

    // Unmapped slot on the 5-slot instance.
    do_req(1'b0, 3'd6, 5'd0, 32'h0, 1'b0, got);

    // Back-to-back with cpu_valid held: alternating write/read.
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] sl;
      logic [4:0] rg;
      sl = 3'($urandom_range(1, 7));
      rg = 5'($urandom_range(3, 31));
      do_req(1'b1, sl, rg, $urandom, 1'b1, got);
      if (k > 0) chk("b2b_spacing_w", 32'(acc_cyc - prev), 32'd3);
      prev = acc_cyc;
      do_req(1'b0, sl, rg, 32'h0, 1'b1, got);
      chk("b2b_spacing_r", 32'(acc_cyc - prev), 32'd3);
      prev = acc_cyc;
    end
    cpu_valid = 1'b0;

    // Reset asserted during ACCESS aborts the request.
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = {3'd3, 5'd4};
    @(posedge clock); #1;
    cpu_valid = 1'b0;
    chk("abort_strobe_seen", 32'(read_a), 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_strobes_a", {cs_a, 22'd0, read_a, write_a}, 32'd0);
    chk("abort_done_a", 32'(done_a), 32'd0);
    chk("abort_ready_a", 32'(ready_a), 32'd1);
    chk("abort_rdata_a", rdata_a, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_no_done_a", 32'(done_a), 32'd0);
    chk("abort_no_done_b", 32'(done_b), 32'd0);
    do_req(1'b0, 3'd3, 5'd4, 32'h0, 1'b0, got);

    // Randomized traffic across the whole address map.
    for (int k = 0; k < 40; k++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)), got);
    end
    cpu_valid = 1'b0;
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
